// File: rtl/sm_stretcher.sv
// Pulse stretcher: each d[i] event becomes a HOLD-cycle high pulse on q[i], followed by GAP forced-low cycles.
// Latency: q[i] and busy[i] rise one cycle after the event edge; both are registered straight off next-state.
// Backpressure: none; events arriving during GAP collapse into one pending event, and HOLD-time events are
// dropped unless SM_STRETCHER_RETRIGGER_EN is defined, in which case they reload the hold counter.
module sm_stretcher #(
    parameter int SIZE = 1,
    parameter int HOLD = 4,
    parameter int GAP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q,
    output logic [SIZE-1:0] busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_RLD = 16'(HOLD - 1);
    localparam logic [15:0] GAP_RLD  = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    for (genvar i = 0; i < SIZE; i++) begin : g_ch
        state_t      state_q, state_d;
        logic [15:0] cnt_q, cnt_d;
        logic        pend_q, pend_d;
        logic        q_q, q_d;
        logic        busy_q, busy_d;
        logic        retrig;

        // Next-state, counter and pending-event logic for this channel
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            retrig  = 1'b0;
`ifdef SM_STRETCHER_RETRIGGER_EN
            retrig  = d[i];
`endif
            case (state_q)
                ST_IDLE: begin
                    if (d[i]) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_RLD;
                    end
                end
                ST_HOLD: begin
                    if (retrig) begin
                        cnt_d = HOLD_RLD;
                    end else if (cnt_q == 16'd0) begin
                        // With no gap, an event on the expiry edge is not seen until the following IDLE edge
                        if (GAP == 0) begin
                            state_d = ST_IDLE;
                            cnt_d   = 16'd0;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_RLD;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (d[i]) begin
                        pend_d = 1'b1;
                    end
                    if (cnt_q == 16'd0) begin
                        // An event on the expiry edge itself still counts as pending so it is not lost
                        if (pend_q || d[i]) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_RLD;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 16'd0;
                        end
                        pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                    pend_d  = 1'b0;
                end
            endcase
            q_d    = (state_d == ST_HOLD);
            busy_d = (state_d != ST_IDLE);
        end

        // Channel state and registered outputs, synchronous reset
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= 16'd0;
                pend_q  <= 1'b0;
                q_q     <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                q_q     <= q_d;
                busy_q  <= busy_d;
            end
        end

        assign q[i]    = q_q;
        assign busy[i] = busy_q;
    end

endmodule

// File: tb/tb_sm_stretcher.sv
// Scoreboarded bench for sm_stretcher: one SIZE=2/HOLD=4/GAP=2 instance and one SIZE=1/GAP=0 instance.
// Stimulus drives on the falling edge and queues the hand-computed q/busy expected after the next rising edge.
// A monitor pops one entry per rising edge (sampled 1 time unit later) and compares against the selected instance.
module tb_sm_stretcher;

    logic       clk;
    logic       rst;
    logic [1:0] d;
    logic [1:0] q0, b0;
    logic [0:0] d1, q1, b1;

    typedef struct {
        logic       sel;
        logic [1:0] q;
        logic [1:0] b;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string tname = "reset";

    sm_stretcher #(.SIZE(2), .HOLD(4), .GAP(2)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .q    (q0),
        .busy (b0)
    );

    sm_stretcher #(.SIZE(1), .HOLD(4), .GAP(0)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .d    (d1),
        .q    (q1),
        .busy (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic bit_at(input string s, input int i);
        return (i < s.len()) && (s[i] == "1");
    endfunction

    // One clock of stimulus plus the expected outputs after the edge that samples it
    task automatic step(input logic sel, input logic r, input logic [1:0] dv,
                        input logic [1:0] eq, input logic [1:0] eb);
        exp_t e;
        @(negedge clk);
        rst = r;
        if (sel) begin
            d  = 2'b00;
            d1 = dv[0:0];
        end else begin
            d  = dv;
            d1 = 1'b0;
        end
        e.sel = sel;
        e.q   = eq;
        e.b   = eb;
        e.tag = tname;
        sb.push_back(e);
    endtask

    // Strings are per-cycle '0'/'1' vectors; an empty string means all zeros
    task automatic run_seq(input string rs,
                           input string ds0, input string qs0, input string bs0,
                           input string ds1, input string qs1, input string bs1);
        for (int i = 0; i < ds0.len(); i++) begin
            step(1'b0, bit_at(rs, i),
                 {bit_at(ds1, i), bit_at(ds0, i)},
                 {bit_at(qs1, i), bit_at(qs0, i)},
                 {bit_at(bs1, i), bit_at(bs0, i)});
        end
    endtask

    // Monitor: compare outputs just after each rising edge against the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t       e;
                logic [1:0] aq, ab;
                e  = sb.pop_front();
                aq = e.sel ? {1'b0, q1} : q0;
                ab = e.sel ? {1'b0, b1} : b0;
                n_cmp++;
                if (aq !== e.q) begin
                    n_err++;
                    $display("FAIL %s q: got %b want %b at %0t", e.tag, aq, e.q, $time);
                end
                n_cmp++;
                if (ab !== e.b) begin
                    n_err++;
                    $display("FAIL %s busy: got %b want %b at %0t", e.tag, ab, e.b, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        d   = 2'b00;
        d1  = 1'b0;

        tname = "reset";
        repeat (3) step(1'b0, 1'b1, 2'b11, 2'b00, 2'b00);

        tname = "single_pulse";
        run_seq("", "1000000", "1111000", "1111110", "", "", "");

        tname = "gap_pending";
        run_seq("", "1000010000000", "1111001111000", "1111111111110",
                    "0010000000000", "0011110000000", "0011111100000");

        tname = "hold_retrigger";
`ifdef SM_STRETCHER_RETRIGGER_EN
        run_seq("", "101000000", "111111000", "111111110", "", "", "");
`else
        run_seq("", "101000000", "111100000", "111111000", "", "", "");
`endif

        tname = "mid_hold_reset";
        run_seq("00100000000", "10110000000", "11011110000", "11011111100",
                "01000000000", "01000000000", "01000000000");

        tname = "held_high_lockstep";
        for (int i = 0; i < 26; i++) begin
            logic eqb, ebb;
`ifdef SM_STRETCHER_RETRIGGER_EN
            eqb = (i < 23);
            ebb = (i < 25);
`else
            eqb = (i < 20) ? ((i % 6) < 4) : (i < 22);
            ebb = (i < 24);
`endif
            step(1'b0, 1'b0, (i < 20) ? 2'b11 : 2'b00, {eqb, eqb}, {ebb, ebb});
        end

        tname = "gap0_held_high";
        for (int i = 0; i < 19; i++) begin
            logic eb1;
`ifdef SM_STRETCHER_RETRIGGER_EN
            eb1 = (i < 18);
`else
            eb1 = (i < 15) && ((i % 5) < 4);
`endif
            step(1'b1, 1'b0, {1'b0, (i < 15)}, {1'b0, eb1}, {1'b0, eb1});
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
